cfg_cmd_buffer: RTL and testbench
=================================

# cfg_cmd_buffer

Receives 35-bit configuration/command words from the serial-to-parallel deserializer. Detects each new word, screens it for illegal opcodes, and queues it in a 4-entry FIFO. Presents decoded commands (opcode, operand A, operand B) to the fault-tolerant ALU core over a valid/ready handshake. Sits directly downstream of the deserializer and upstream of the ALU issue logic, decoupling serial arrival rate from ALU acceptance.

## Interface
Parameters:
- SIZE, 35, command word width; must equal OPW + 2*DW
- OPW, 3, opcode field width
- DW, 16, operand width
- DEPTH, 4, FIFO entries (power of two)

Ports:
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- cfg_word  in  SIZE  parallel word from deserializer; stable whenever load_flag is high
- load_flag  in  1  deserializer "word ready" level; held high until the next word starts shifting
- cmd_valid  out  1  head entry available
- cmd_ready  in  1  ALU accepts head entry
- cmd_opcode  out  OPW  cfg_word[34:32] of head entry
- cmd_op_a  out  DW  cfg_word[31:16] of head entry
- cmd_op_b  out  DW  cfg_word[15:0] of head entry
- fifo_count  out  3  entries held, 0..4
- overflow  out  1  sticky: a legal word was dropped because the FIFO was full
- illegal_op  out  1  sticky: a word with opcode 3'b110 or 3'b111 was dropped
- clr_flags  in  1  clears overflow and illegal_op

## Operation
- load_flag is a level, not a pulse. The block registers load_prev and generates new_word = load_flag & ~load_prev. Only the rising edge of load_flag captures cfg_word.
- Legal opcodes: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL. Opcodes 110 and 111 are never enqueued; new_word with either sets illegal_op.
- Push = new_word & legal & (count < DEPTH | pop). Pop = cmd_valid & cmd_ready.
- Full, no pop, legal new_word: word dropped, overflow set, FIFO unchanged.
- Full with simultaneous pop: push accepted, count stays 4, head advances.
- Empty with push: no bypass. The entry is written at the capture edge.
- Pointers are 2-bit and wrap modulo DEPTH. count is tracked separately (0..4) and drives full/empty.
- Sticky flags: a set event in the same cycle as clr_flags wins (flag ends at 1).
- cmd_* outputs reflect the head entry combinationally from FIFO storage. They are undefined-but-stable (held last value) when cmd_valid=0.

## Timing
- Reset values: cmd_valid 0, cmd_opcode/op_a/op_b 0, fifo_count 0, overflow 0, illegal_op 0, pointers 0, load_prev 1.
- load_prev resets to 1 so that a load_flag still high at reset release is not treated as a new word.
- Latency: load_flag rises in cycle N, capture happens at the edge ending cycle N, and cmd_valid=1 with fields valid in cycle N+1.
- Handshake: an entry retires at the edge where cmd_valid & cmd_ready. cmd_valid never drops without a pop, and fields are stable while cmd_valid & ~cmd_ready.
- Throughput: one push and one pop per cycle.
- Reset mid-operation flushes all entries in one cycle. Words in flight are lost and flags are cleared.

## Structure
- Package alu_cfg_pkg holds:
  - opcode enum (ADD..SHL, plus RSV6/RSV7)
  - field position constants (OP_MSB=34, OP_LSB=32, A_MSB=31, A_LSB=16, B_MSB=15, B_LSB=0)
  - function is_legal_op
- Sub-module cfg_sync_fifo is a generic synchronous FIFO (WIDTH, DEPTH; push, pop, count, head data). cfg_cmd_buffer contains the edge detect, decode/screen, and flag logic around it.

## Test plan
- Single word: cfg_word=35'h1123400FF, load_flag 0→1 and held 10 cycles, cmd_ready=0. Expect one entry only: cmd_valid=1 one cycle after the edge, opcode=001, op_a=16'h1234, op_b=16'h00FF, fifo_count=1.
- Fill/overflow: five legal words with cmd_ready=0. Expect fifo_count=4 and overflow=1; a 6th word with cmd_ready=1 in the same cycle is accepted, count stays 4, head advances.
- Illegal opcode: cfg_word={3'b110,32'hDEADBEEF}. Expect illegal_op=1 and fifo_count unchanged. Then clr_flags=1 for one cycle: illegal_op=0 next cycle.
- Order/wrap: 10 words pushed while cmd_ready toggles 1/0. Expect pops in push order with pointer wrap exercised, and no loss while count<4.
- Reset mid-stream: rst=1 for one cycle with 3 entries queued and load_flag=1. Expect all outputs at reset values next cycle, and no capture until load_flag falls and rises again.
- Flag race: overflow event and clr_flags in the same cycle. Expect overflow=1 afterwards.

Source files
------------

// File: rtl/alu_cfg_pkg.sv
// Shared definitions for the configuration command path: opcode encoding,
// command-word field positions and the opcode legality screen.
package alu_cfg_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_SUB  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_XOR  = 3'b100,
        OP_SHL  = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } opcode_e;

    localparam int OP_MSB = 34;
    localparam int OP_LSB = 32;
    localparam int A_MSB  = 31;
    localparam int A_LSB  = 16;
    localparam int B_MSB  = 15;
    localparam int B_LSB  = 0;

    // The two reserved encodings must never reach the ALU issue logic.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op != OP_RSV6) && (op != OP_RSV7);
    endfunction

endpackage

// File: rtl/cfg_sync_fifo.sv
// Generic single-clock FIFO with explicit occupancy count and combinational
// head read. DEPTH must be a power of two (>= 2) so pointers wrap naturally.
module cfg_sync_fifo #(
    parameter int WIDTH = 35,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head_data,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == CW'(DEPTH));

    // A push into a full FIFO is only safe when the head retires on the same edge.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is cleared on reset so the head fields read zero afterwards.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/cfg_cmd_buffer.sv
// Captures deserialized command words on the rising edge of load_flag, drops
// reserved opcodes, queues legal words and presents the head to the ALU.
module cfg_cmd_buffer
    import alu_cfg_pkg::*;
#(
    parameter int SIZE  = 35,
    parameter int OPW   = 3,
    parameter int DW    = 16,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [SIZE-1:0] cfg_word,
    input  logic            load_flag,
    output logic            cmd_valid,
    input  logic            cmd_ready,
    output logic [OPW-1:0]  cmd_opcode,
    output logic [DW-1:0]   cmd_op_a,
    output logic [DW-1:0]   cmd_op_b,
    output logic [2:0]      fifo_count,
    output logic            overflow,
    output logic            illegal_op,
    input  logic            clr_flags
);

    logic                       load_prev_q;
    logic                       overflow_q, overflow_d;
    logic                       illegal_op_q, illegal_op_d;
    logic [2:0]                 word_op;
    logic                       new_word, word_legal;
    logic                       push, pop;
    logic                       overflow_evt, illegal_evt;
    logic                       fifo_full, fifo_empty;
    logic [SIZE-1:0]            head_word;
    logic [$clog2(DEPTH+1)-1:0] count;

    assign word_op    = cfg_word[OP_MSB:OP_LSB];
    assign new_word   = load_flag & ~load_prev_q;
    assign word_legal = is_legal_op(word_op);

    assign pop          = ~fifo_empty & cmd_ready;
    assign push         = new_word & word_legal & (~fifo_full | pop);
    assign overflow_evt = new_word & word_legal & fifo_full & ~pop;
    assign illegal_evt  = new_word & ~word_legal;

    // A set event outranks a simultaneous clear so no drop goes unreported.
    always_comb begin
        overflow_d   = overflow_q;
        illegal_op_d = illegal_op_q;
        if (overflow_evt) begin
            overflow_d = 1'b1;
        end else if (clr_flags) begin
            overflow_d = 1'b0;
        end
        if (illegal_evt) begin
            illegal_op_d = 1'b1;
        end else if (clr_flags) begin
            illegal_op_d = 1'b0;
        end
    end

    // load_prev resets high so a level still asserted at reset release is ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            load_prev_q  <= 1'b1;
            overflow_q   <= 1'b0;
            illegal_op_q <= 1'b0;
        end else begin
            load_prev_q  <= load_flag;
            overflow_q   <= overflow_d;
            illegal_op_q <= illegal_op_d;
        end
    end

    cfg_sync_fifo #(
        .WIDTH (SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .wdata     (cfg_word),
        .head_data (head_word),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign cmd_valid  = ~fifo_empty;
    assign cmd_opcode = head_word[OP_MSB:OP_LSB];
    assign cmd_op_a   = head_word[A_MSB:A_LSB];
    assign cmd_op_b   = head_word[B_MSB:B_LSB];
    assign fifo_count = 3'(count);
    assign overflow   = overflow_q;
    assign illegal_op = illegal_op_q;

endmodule

// File: tb/tb_cfg_cmd_buffer.sv
// Directed bench for cfg_cmd_buffer: a vector table for single-word, illegal
// opcode and clear behaviour, then queue-model sequences for the corner cases.
module tb_cfg_cmd_buffer;

    logic        clk;
    logic        rst;
    logic [34:0] cfg_word;
    logic        load_flag;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_opcode;
    logic [15:0] cmd_op_a;
    logic [15:0] cmd_op_b;
    logic [2:0]  fifo_count;
    logic        overflow;
    logic        illegal_op;
    logic        clr_flags;

    cfg_cmd_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_word   (cfg_word),
        .load_flag  (load_flag),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_op_a   (cmd_op_a),
        .cmd_op_b   (cmd_op_b),
        .fifo_count (fifo_count),
        .overflow   (overflow),
        .illegal_op (illegal_op),
        .clr_flags  (clr_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic        lf;
        logic [34:0] word;
        logic        rdy;
        logic        clr;
        logic        e_valid;
        logic [2:0]  e_op;
        logic [15:0] e_a;
        logic [15:0] e_b;
        logic [2:0]  e_cnt;
        logic        e_ovf;
        logic        e_ill;
        logic        chk_fields;
    } vec_t;

    localparam logic [34:0] W1 = 35'h1123400FF;
    localparam logic [34:0] WI = {3'b110, 32'hDEADBEEF};
    localparam logic [34:0] W2 = {3'b100, 16'hA5A5, 16'h5A5A};

    vec_t        vecs [10];
    int          n_pass = 0;
    int          n_total = 0;
    logic [34:0] mq [$];
    logic        m_ovf = 1'b0;
    logic        m_ill = 1'b0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [34:0] mkw(input int k);
        return {3'(k % 6), 16'(16'hA000 + k), 16'(16'h5000 + 3 * k)};
    endfunction

    task automatic check_state(input string name);
        logic [34:0] h;
        chk({name, "_valid"}, cmd_valid, mq.size() > 0);
        chk({name, "_count"}, fifo_count, mq.size());
        chk({name, "_ovf"}, overflow, m_ovf);
        chk({name, "_ill"}, illegal_op, m_ill);
        if (mq.size() > 0) begin
            h = mq[0];
            chk({name, "_op"}, cmd_opcode, h[34:32]);
            chk({name, "_a"}, cmd_op_a, h[31:16]);
            chk({name, "_b"}, cmd_op_b, h[15:0]);
        end
    endtask

    // One low cycle, then a rising load_flag with the given ready/clear.
    task automatic send_word(input logic [34:0] w, input logic rdy, input logic clr);
        logic legal_m, pop_m, push_m;
        load_flag = 1'b0; cmd_ready = 1'b0; clr_flags = 1'b0;
        step();
        load_flag = 1'b1; cfg_word = w; cmd_ready = rdy; clr_flags = clr;
        legal_m = (w[34:32] < 3'd6);
        pop_m   = rdy && (mq.size() > 0);
        push_m  = legal_m && ((mq.size() < 4) || pop_m);
        step();
        if (pop_m) void'(mq.pop_front());
        if (push_m) mq.push_back(w);
        if (legal_m && !push_m) m_ovf = 1'b1; else if (clr) m_ovf = 1'b0;
        if (!legal_m) m_ill = 1'b1; else if (clr) m_ill = 1'b0;
        cmd_ready = 1'b0; clr_flags = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int g = 0; g < 8 && mq.size() > 0; g++) begin
            cmd_ready = 1'b1;
            step();
            void'(mq.pop_front());
            check_state(name);
        end
        cmd_ready = 1'b0;
        chk({name, "_empty"}, fifo_count, 0);
    endtask

    initial begin
        vecs[0] = '{1'b1, W1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{1'b1, W1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{1'b1, W1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{1'b0, W1, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{1'b1, WI, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b1, 1'b1};
        vecs[5] = '{1'b1, WI, 1'b0, 1'b0, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b1, 1'b1};
        vecs[6] = '{1'b0, WI, 1'b0, 1'b1, 1'b1, 3'd1, 16'h1234, 16'h00FF, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[7] = '{1'b1, W2, 1'b1, 1'b0, 1'b1, 3'd4, 16'hA5A5, 16'h5A5A, 3'd1, 1'b0, 1'b0, 1'b1};
        vecs[8] = '{1'b0, W2, 1'b1, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0};
        vecs[9] = '{1'b0, W2, 1'b0, 1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 3'd0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; load_flag = 1'b0; cfg_word = '0; cmd_ready = 1'b0; clr_flags = 1'b0;
        step();
        step();
        rst = 1'b0;
        step();
        chk("rst_valid", cmd_valid, 0);
        chk("rst_op", cmd_opcode, 0);
        chk("rst_a", cmd_op_a, 0);
        chk("rst_b", cmd_op_b, 0);
        chk("rst_count", fifo_count, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_ill", illegal_op, 0);

        for (int i = 0; i < 10; i++) begin
            load_flag = vecs[i].lf;
            cfg_word  = vecs[i].word;
            cmd_ready = vecs[i].rdy;
            clr_flags = vecs[i].clr;
            if (i == 0) chk("no_bypass", cmd_valid, 0);
            step();
            chk($sformatf("vec%0d_valid", i), cmd_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d_count", i), fifo_count, vecs[i].e_cnt);
            chk($sformatf("vec%0d_ovf", i), overflow, vecs[i].e_ovf);
            chk($sformatf("vec%0d_ill", i), illegal_op, vecs[i].e_ill);
            if (vecs[i].chk_fields) begin
                chk($sformatf("vec%0d_op", i), cmd_opcode, vecs[i].e_op);
                chk($sformatf("vec%0d_a", i), cmd_op_a, vecs[i].e_a);
                chk($sformatf("vec%0d_b", i), cmd_op_b, vecs[i].e_b);
            end
        end
        cmd_ready = 1'b0; clr_flags = 1'b0;

        // Fill to four, drop the fifth, then push into full with a pop.
        for (int k = 0; k < 5; k++) begin
            send_word(mkw(k), 1'b0, 1'b0);
            check_state($sformatf("fill%0d", k));
        end
        send_word(mkw(5), 1'b1, 1'b0);
        check_state("full_pop");

        clr_flags = 1'b1;
        step();
        clr_flags = 1'b0;
        m_ovf = 1'b0; m_ill = 1'b0;
        check_state("clr");

        send_word(mkw(6), 1'b0, 1'b1);
        check_state("race");
        drain("drain1");

        // Ten words with ready cycling 0,0,1,1 against a push every other cycle.
        for (int c = 0; c < 20; c++) begin
            logic pop_m, push_m, rise;
            rise      = (c % 2 == 1);
            load_flag = rise;
            cfg_word  = mkw(20 + c / 2);
            cmd_ready = ((c / 2) % 2 == 1);
            pop_m     = cmd_ready && (mq.size() > 0);
            push_m    = rise && ((mq.size() < 4) || pop_m);
            step();
            if (pop_m) void'(mq.pop_front());
            if (push_m) mq.push_back(cfg_word);
            if (rise && !push_m) m_ovf = 1'b1;
            check_state($sformatf("wrap%0d", c));
        end
        cmd_ready = 1'b0;
        drain("drain2");

        send_word(WI, 1'b0, 1'b0);
        for (int k = 30; k < 33; k++) send_word(mkw(k), 1'b0, 1'b0);
        check_state("pre_rst");
        rst = 1'b1;
        step();
        rst = 1'b0;
        mq.delete();
        m_ovf = 1'b0; m_ill = 1'b0;
        chk("mid_rst_valid", cmd_valid, 0);
        chk("mid_rst_op", cmd_opcode, 0);
        chk("mid_rst_a", cmd_op_a, 0);
        chk("mid_rst_b", cmd_op_b, 0);
        chk("mid_rst_count", fifo_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_ill", illegal_op, 0);
        for (int k = 0; k < 3; k++) begin
            step();
            check_state($sformatf("rst_hold%0d", k));
        end
        send_word(mkw(33), 1'b0, 1'b0);
        check_state("post_rst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
